// File: rtl/xor_share_sched.sv
// Round-robin scheduler that time-shares one external 1-bit XOR cell among NREQ
// requesters, streaming operand pairs LSB-first and reassembling the W-bit result.
module xor_share_sched #(
   parameter int W    = 8,
   parameter int NREQ = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] a_in,
   input  logic [NREQ*W-1:0] b_in,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic [W-1:0]      res,
   output logic              busy,
   output logic              xor_a,
   output logic              xor_b,
   input  logic              xor_y
);

   localparam int CW = $clog2(W);
   localparam int PW = $clog2(NREQ);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_t;

   state_t          state;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   win;
   logic [CW-1:0]   cnt;
   logic [W-1:0]    sh_a;
   logic [W-1:0]    sh_b;
   logic [W-1:0]    acc;

   logic [W-1:0]    a_arr [NREQ];
   logic [W-1:0]    b_arr [NREQ];
   logic [PW-1:0]   pick;
   logic            pick_ok;
   int              idx;

   for (genvar k = 0; k < NREQ; k++) begin : g_unpack
      assign a_arr[k] = a_in[k*W +: W];
      assign b_arr[k] = b_in[k*W +: W];
   end

   // Shift registers drain to zero after W shifts, so the cell sees 0/0 whenever
   // no operation is streaming, straight from flops with no gating logic.
   assign xor_a = sh_a[0];
   assign xor_b = sh_b[0];

   // Scan downward so the requester closest to ptr (wrapping upward) overwrites last.
   always_comb begin
      // NOTE: every comb output gets a default first; a missed branch would infer a latch.
      pick    = '0;
      pick_ok = 1'b0;
      idx     = 0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req[PW'(idx)]) begin
            pick    = PW'(idx);
            pick_ok = 1'b1;
         end
      end
   end

   // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         ptr   <= '0;
         win   <= '0;
         cnt   <= '0;
         sh_a  <= '0;
         sh_b  <= '0;
         acc   <= '0;
         gnt   <= '0;
         done  <= '0;
         res   <= '0;
         busy  <= 1'b0;
      end else begin
         done <= '0;
         case (state)
            ST_IDLE: begin
               if (pick_ok) begin
                  sh_a  <= a_arr[pick];
                  sh_b  <= b_arr[pick];
                  gnt   <= NREQ'(1) << pick;
                  win   <= pick;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // Result bits come only from the external cell, never recomputed here.
               acc[cnt] <= xor_y;
               sh_a     <= sh_a >> 1;
               sh_b     <= sh_b >> 1;
               cnt      <= cnt + 1'b1;
               if (cnt == CW'(W - 1)) state <= ST_DONE;
            end
            ST_DONE: begin
               res   <= acc;
               done  <= gnt;
               gnt   <= '0;
               busy  <= 1'b0;
               ptr   <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xor_share_sched.sv
// Self-checking bench for xor_share_sched: directed vector table, hand-written
// corner sequences, and randomized traffic against a round-robin reference model.
module tb_xor_share_sched;

   localparam int W    = 8;
   localparam int NREQ = 2;
   localparam int LAT  = W + 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] a_in;
   logic [NREQ*W-1:0] b_in;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   done;
   logic [W-1:0]      res;
   logic              busy;
   logic              xor_a;
   logic              xor_b;
   logic              xor_y;

   int checks   = 0;
   int failures = 0;
   int mode     = 0;   // external cell: 0 ideal XOR, 1 stuck-at-0, 2 XNOR

   always #5 clk = ~clk;

   assign xor_y = (mode == 1) ? 1'b0 :
                  (mode == 2) ? ~(xor_a ^ xor_b) : (xor_a ^ xor_b);

   xor_share_sched #(.W(W), .NREQ(NREQ)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .a_in  (a_in),
      .b_in  (b_in),
      .gnt   (gnt),
      .done  (done),
      .res   (res),
      .busy  (busy),
      .xor_a (xor_a),
      .xor_b (xor_b),
      .xor_y (xor_y)
   );

   typedef struct {
      bit             pre_rst;
      int             mode;
      logic [1:0]     req;
      logic [7:0]     a0, b0, a1, b1;
      logic [1:0]     exp_done;
      logic [7:0]     exp_res;
   } vec_t;

   vec_t tbl [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Waits (bounded) for a done pulse; reports grant/busy seen one cycle in and
   // whether gnt/done stayed one-hot-or-zero throughout.
   task automatic wait_done(output logic [1:0] d, output logic [7:0] r, output int n,
                            output logic [1:0] g1, output logic bz1, output bit oh);
      d = '0; r = '0; n = 0; g1 = '0; bz1 = 1'b0; oh = 1'b1;
      while (n < 4 * LAT && d == '0) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            g1  = gnt;
            bz1 = busy;
         end
         if ($countones(gnt) > 1 || $countones(done) > 1) oh = 1'b0;
         if (done != '0) begin
            d = done;
            r = res;
         end
      end
   endtask

   function automatic int rr_pick(input logic [1:0] pend, input int ptr);
      for (int i = 0; i < NREQ; i++)
         if (pend[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
      return -1;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] d, g1;
      logic [7:0] r;
      logic       bz1;
      bit         oh;
      int         n;
      logic [1:0] pend;
      logic [7:0] ra [NREQ];
      logic [7:0] rb [NREQ];
      int         ptr_m, w;

      // pre_rst, mode, req, a0, b0, a1, b1, exp_done, exp_res
      tbl[0] = '{1'b0, 0, 2'b01, 8'hA5, 8'h3C, 8'h00, 8'h00, 2'b01, 8'h99};
      tbl[1] = '{1'b1, 0, 2'b11, 8'hFF, 8'h0F, 8'h55, 8'h55, 2'b01, 8'hF0};
      tbl[2] = '{1'b0, 0, 2'b10, 8'hFF, 8'h0F, 8'h55, 8'h55, 2'b10, 8'h00};
      tbl[3] = '{1'b0, 1, 2'b01, 8'hFF, 8'h00, 8'h00, 8'h00, 2'b01, 8'h00};
      // XNOR cell: FF/00 yields 00 and 00/00 yields FF, unlike a true XOR
      tbl[4] = '{1'b0, 2, 2'b01, 8'hFF, 8'h00, 8'h00, 8'h00, 2'b01, 8'h00};
      tbl[5] = '{1'b0, 2, 2'b01, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 8'hFF};
      tbl[6] = '{1'b1, 0, 2'b11, 8'h12, 8'h34, 8'hF0, 8'h3C, 2'b01, 8'h26};
      tbl[7] = '{1'b0, 0, 2'b11, 8'h12, 8'h34, 8'hF0, 8'h3C, 2'b10, 8'hCC};
      tbl[8] = '{1'b0, 0, 2'b11, 8'h12, 8'h34, 8'hF0, 8'h3C, 2'b01, 8'h26};
      tbl[9] = '{1'b0, 0, 2'b11, 8'h12, 8'h34, 8'hF0, 8'h3C, 2'b10, 8'hCC};

      rst_n = 1'b0;
      req   = '0;
      a_in  = '0;
      b_in  = '0;
      #1;
      check("rst_gnt",  32'(gnt),   32'h0);
      check("rst_done", 32'(done),  32'h0);
      check("rst_res",  32'(res),   32'h0);
      check("rst_busy", 32'(busy),  32'h0);
      check("rst_xa",   32'(xor_a), 32'h0);
      check("rst_xb",   32'(xor_b), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         if (tbl[i].pre_rst) do_reset();
         mode = tbl[i].mode;
         req  = tbl[i].req;
         a_in = {tbl[i].a1, tbl[i].a0};
         b_in = {tbl[i].b1, tbl[i].b0};
         wait_done(d, r, n, g1, bz1, oh);
         check($sformatf("v%0d_gnt", i),    32'(g1),   32'(tbl[i].exp_done));
         check($sformatf("v%0d_busy1", i),  32'(bz1),  32'h1);
         check($sformatf("v%0d_done", i),   32'(d),    32'(tbl[i].exp_done));
         check($sformatf("v%0d_res", i),    32'(r),    32'(tbl[i].exp_res));
         check($sformatf("v%0d_lat", i),    32'(n),    32'(LAT));
         check($sformatf("v%0d_busy0", i),  32'(busy), 32'h0);
         check($sformatf("v%0d_onehot", i), 32'(oh),   32'h1);
         req = '0;
      end
      mode = 0;

      // Reset in the middle of SHIFT: everything clears at once, no done pulse.
      req  = 2'b01;
      a_in = {8'h00, 8'hA5};
      b_in = {8'h00, 8'h3C};
      repeat (5) @(negedge clk);
      check("mid_busy", 32'(busy), 32'h1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_gnt",  32'(gnt),   32'h0);
      check("mid_rst_done", 32'(done),  32'h0);
      check("mid_rst_res",  32'(res),   32'h0);
      check("mid_rst_busy", 32'(busy),  32'h0);
      check("mid_rst_xa",   32'(xor_a), 32'h0);
      check("mid_rst_xb",   32'(xor_b), 32'h0);
      req = 2'b00;
      @(negedge clk);
      check("mid_rst_nodone", 32'(done), 32'h0);
      rst_n = 1'b1;
      req   = 2'b10;
      a_in  = {8'h6B, 8'hA5};
      b_in  = {8'h0F, 8'h3C};
      wait_done(d, r, n, g1, bz1, oh);
      check("post_rst_done", 32'(d), 32'h2);
      check("post_rst_res",  32'(r), 32'h64);
      check("post_rst_lat",  32'(n), 32'(LAT));
      req = '0;

      // Drop req and change operands at bit 2: latched operands still complete.
      req  = 2'b01;
      a_in = {8'h00, 8'hC3};
      b_in = {8'h00, 8'h5A};
      repeat (3) @(negedge clk);
      req  = 2'b00;
      a_in = {8'h00, 8'h00};
      wait_done(d, r, n, g1, bz1, oh);
      check("drop_done", 32'(d), 32'h1);
      check("drop_res",  32'(r), 32'h99);
      check("drop_lat",  32'(n), 32'(LAT - 3));
      @(negedge clk);
      check("drop_idle_busy", 32'(busy), 32'h0);
      check("drop_idle_gnt",  32'(gnt),  32'h0);
      check("drop_done_pulse", 32'(done), 32'h0);

      // Randomized traffic against a round-robin model.
      do_reset();
      pend  = '0;
      ptr_m = 0;
      for (int k = 0; k < NREQ; k++) begin
         ra[k] = '0;
         rb[k] = '0;
      end
      for (int rnd = 0; rnd < 40; rnd++) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!pend[k] && $urandom_range(0, 1) == 1) begin
               pend[k] = 1'b1;
               ra[k]   = 8'($urandom);
               rb[k]   = 8'($urandom);
            end
         end
         if (pend == '0) begin
            w       = int'($urandom_range(0, NREQ - 1));
            pend[w] = 1'b1;
            ra[w]   = 8'($urandom);
            rb[w]   = 8'($urandom);
         end
         req  = pend;
         a_in = {ra[1], ra[0]};
         b_in = {rb[1], rb[0]};
         w    = rr_pick(pend, ptr_m);
         wait_done(d, r, n, g1, bz1, oh);
         check($sformatf("rnd%0d_done", rnd), 32'(d), 32'(1 << w));
         check($sformatf("rnd%0d_res", rnd),  32'(r), 32'(ra[w] ^ rb[w]));
         check($sformatf("rnd%0d_lat", rnd),  32'(n), 32'(LAT));
         check($sformatf("rnd%0d_oh", rnd),   32'(oh), 32'h1);
         pend[w] = 1'b0;
         ptr_m   = (w + 1) % NREQ;
         req     = pend;
      end
      req = '0;
      repeat (2 * LAT) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
